// File: rtl/if_stage_ctrl.sv
`default_nettype none
// ============================================================================
// if_stage_ctrl : PC and IF/ID register owner with stall/redirect/imem handshake
// Revision 1.0
// ============================================================================
module if_stage_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             id_ex_ctrl_zero,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] instr_nxt;
    logic [31:0] pc4_nxt;
    logic        valid_nxt;
    logic        req;

    assign pc_plus4        = pc + 32'd4;
    assign imem_addr       = pc;
    assign imem_req        = req;
    assign id_ex_ctrl_zero = stall_req;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = if_id_instr;
        pc4_nxt   = if_id_pc4;
        valid_nxt = if_id_valid;
        // A stall freezes everything; branch operands are not trustworthy then.
        if (!stall_req) begin
            if (branch_taken) begin
                pc_nxt    = branch_target;
                instr_nxt = 32'h0;
                valid_nxt = 1'b0;
                state_nxt = ST_RUN;
            end else if (imem_ready) begin
                instr_nxt = imem_instr;
                pc4_nxt   = pc_plus4;
                valid_nxt = 1'b1;
                pc_nxt    = pc_plus4;
                state_nxt = ST_RUN;
            end else begin
                instr_nxt = 32'h0;
                valid_nxt = 1'b0;
                state_nxt = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            req         <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            if_id_instr <= instr_nxt;
            if_id_pc4   <= pc4_nxt;
            if_id_valid <= valid_nxt;
            req         <= 1'b1;
        end
    end

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_req && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!stall_req && branch_taken && !(&flush_cnt)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage_ctrl.sv
`default_nettype none
// ============================================================================
// tb_if_stage_ctrl : randomized self-checking bench with behavioural fetch model
// Revision 1.0
// ============================================================================
module tb_if_stage_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          CNT_W    = 16;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             stall_req;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic [31:0]      imem_addr;
    logic             imem_req;
    logic             imem_ready;
    logic [31:0]      imem_instr;
    logic [31:0]      if_id_instr;
    logic [31:0]      if_id_pc4;
    logic             if_id_valid;
    logic             id_ex_ctrl_zero;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    if_stage_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ready(imem_ready), .imem_instr(imem_instr), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .id_ex_ctrl_zero(id_ex_ctrl_zero),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: architectural fetch state, true (unclamped) event counts.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    int          m_stalls;
    int          m_flushes;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] clamp(input int n);
        return (n > CNT_MAX) ? 32'(CNT_MAX) : 32'(n);
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_stalls = 0; m_flushes = 0;
    endtask

    task automatic check_regs();
        check("imem_req", {31'h0, imem_req}, 32'h1);
        check("imem_addr", imem_addr, m_pc);
        check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        check("if_id_instr", if_id_instr, m_instr);
        if (m_valid) check("if_id_pc4", if_id_pc4, m_pc4);
        check("stall_cnt", {16'h0, stall_cnt}, clamp(m_stalls));
        check("flush_cnt", {16'h0, flush_cnt}, clamp(m_flushes));
    endtask

    // One pipeline cycle: drive, check combinational bubble, clock, check state.
    task automatic cycle(input logic s, input logic b, input logic [31:0] t,
                         input logic r, input logic [31:0] ins, input logic full);
        stall_req = s; branch_taken = b; branch_target = t; imem_ready = r; imem_instr = ins;
        #1;
        check("id_ex_ctrl_zero", {31'h0, id_ex_ctrl_zero}, {31'h0, s});
        @(posedge clk);
        if (s) begin
            m_stalls++;
        end else if (b) begin
            m_pc = t; m_instr = 32'h0; m_valid = 1'b0; m_flushes++;
        end else if (r) begin
            m_instr = ins; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end else begin
            m_instr = 32'h0; m_valid = 1'b0;
        end
        #1;
        if (full) check_regs();
    endtask

    initial begin
        rst_n = 1'b0; stall_req = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        imem_ready = 1'b0; imem_instr = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", imem_addr, RESET_PC);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        stall_req = 1'b1; #1;
        check("rst_ctrl_zero", {31'h0, id_ex_ctrl_zero}, 32'h1);
        stall_req = 1'b0;
        rst_n = 1'b1;

        // Streaming fetch from reset PC.
        cycle(0, 0, 0, 1, 32'h2000_0001, 1);
        check("seq_addr1", imem_addr, 32'h104);
        cycle(0, 0, 0, 1, 32'h8C08_0000, 1);
        check("seq_pc4", if_id_pc4, 32'h108);
        check("seq_addr2", imem_addr, 32'h108);

        // Load-use stall with concurrent ready: IF/ID and PC held, data dropped.
        cycle(1, 0, 0, 1, 32'hDEAD_BEEF, 1);
        check("lu_instr", if_id_instr, 32'h8C08_0000);
        check("lu_pc4", if_id_pc4, 32'h108);
        check("lu_addr", imem_addr, 32'h108);
        check("lu_stall_cnt", {16'h0, stall_cnt}, 32'h1);
        cycle(0, 0, 0, 1, 32'h0000_0020, 1);

        // Taken branch discards concurrent ready.
        cycle(0, 1, 32'h200, 1, 32'hBAD0_0000, 1);
        check("br_addr", imem_addr, 32'h200);
        check("br_valid", {31'h0, if_id_valid}, 32'h0);
        check("br_flush_cnt", {16'h0, flush_cnt}, 32'h1);
        cycle(0, 0, 0, 1, 32'h1111_1111, 1);
        check("br_pc4", if_id_pc4, 32'h204);

        // Slow memory at 0x40.
        cycle(0, 1, 32'h40, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 32'h5555_5555, 1);
        check("wait_addr", imem_addr, 32'h40);
        cycle(0, 0, 0, 1, 32'h0109_5020, 1);
        check("wait_instr", if_id_instr, 32'h0109_5020);
        check("wait_pc4", if_id_pc4, 32'h44);

        // Stall masks branch; branch takes effect once stall drops.
        cycle(1, 1, 32'h300, 1, 0, 1);
        check("sb_addr", imem_addr, 32'h44);
        cycle(0, 1, 32'h300, 0, 0, 1);
        check("sb_redirect", imem_addr, 32'h300);

        // PC wrap at top of address space, plus unaligned target taken verbatim.
        cycle(0, 1, 32'hFFFF_FFFC, 0, 0, 1);
        cycle(0, 0, 0, 1, 32'h7777_7777, 1);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4", if_id_pc4, 32'h0);
        cycle(0, 1, 32'h0000_0123, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 5) == 0, ($urandom % 4) == 0, $urandom,
                  ($urandom % 3) != 0, $urandom, 1);
        end

        // Stall counter saturation, then asynchronous reset mid-stall.
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            cycle(1, ($urandom % 2) == 1, $urandom, ($urandom % 2) == 1, $urandom, 0);
        end
        check_regs();
        check("sat_stall_cnt", {16'h0, stall_cnt}, 32'h0000_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", imem_addr, RESET_PC);
        check("mid_rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
        check("mid_rst_flush_cnt", {16'h0, flush_cnt}, 32'h0);
        check("mid_rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("mid_rst_instr", if_id_instr, 32'h0);
        check("mid_rst_pc4", if_id_pc4, 32'h0);
        check("mid_rst_req", {31'h0, imem_req}, 32'h0);
        check("mid_rst_ctrl_zero", {31'h0, id_ex_ctrl_zero}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
